// File: rtl/inst_memory.sv
// Purpose : byte-addressed read-only instruction ROM for the fetch stage; returns the
//           little-endian 32-bit word starting at PC, bytes past the end read as zero.
// Latency : 1 cycle (PC sampled on rising clk, word held until the next edge).
// Backpressure: none; a new fetch is accepted every cycle.
// Ports   : clk (rising edge), reset (async, active-low), PC[31:0] byte address,
//           instruction_code[31:0] registered fetch word (0 while in reset).
module inst_memory #(
  parameter int DEPTH_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic [31:0] instruction_code
);

  localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  logic [7:0]  r_mem [DEPTH_BYTES];
  logic [31:0] r_instr;
  logic [31:0] w_word;

  // Boot program image: add x6,x8,x9 / sub x5,x18,x19 / sw x6,8(x9).
  function automatic logic [7:0] boot_byte(input int a);
    case (a)
      0:  boot_byte = 8'h33;
      1:  boot_byte = 8'h03;
      2:  boot_byte = 8'h94;
      3:  boot_byte = 8'h00;
      4:  boot_byte = 8'hB3;
      5:  boot_byte = 8'h02;
      6:  boot_byte = 8'h39;
      7:  boot_byte = 8'h41;
      8:  boot_byte = 8'h23;
      9:  boot_byte = 8'hA4;
      10: boot_byte = 8'h64;
      11: boot_byte = 8'h00;
      default: boot_byte = 8'h00;
    endcase
  endfunction

  // Image is (re)loaded only under reset; there is no write path otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        r_mem[i] <= boot_byte(i);
      end
    end
  end

  // Byte addresses are formed at 33 bits so that PC+k overflow past 32'hFFFFFFFF
  // lands out of range instead of wrapping back onto mem[0..2].
  always_comb begin
    logic [32:0] w_addr;
    w_word = '0;
    w_addr = '0;
    for (int k = 0; k < 4; k++) begin
      w_addr = {1'b0, PC} + 33'(k);
      if (w_addr < 33'(DEPTH_BYTES)) begin
        w_word[8*k +: 8] = r_mem[w_addr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr <= '0;
    end else begin
      r_instr <= w_word;
    end
  end

  assign instruction_code = r_instr;

endmodule

// File: tb/tb_inst_memory.sv
// Testbench for inst_memory: table of directed fetches plus hand-written
// sequences for reset, latency/hold and asynchronous mid-run reset.
module tb_inst_memory;

  logic        clk;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] instruction_code;

  int n_vec;
  int n_err;

  inst_memory #(.DEPTH_BYTES(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .PC               (PC),
    .instruction_code (instruction_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fetch(input logic [31:0] pc);
    PC = pc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    realtime t0;
    n_vec = 0;
    n_err = 0;

    vecs.push_back('{"aligned pc4",   32'd4,          32'h413902B3});
    vecs.push_back('{"aligned pc8",   32'd8,          32'h0064A423});
    vecs.push_back('{"aligned pc12",  32'd12,         32'h00000000});
    vecs.push_back('{"unaligned pc1", 32'd1,          32'hB3009403});
    vecs.push_back('{"unaligned pc2", 32'd2,          32'h02B30094});
    vecs.push_back('{"unaligned pc3", 32'd3,          32'h3902B300});
    vecs.push_back('{"unaligned pc5", 32'd5,          32'h23413902});
    vecs.push_back('{"unaligned pc6", 32'd6,          32'hA4234139});
    vecs.push_back('{"unaligned pc7", 32'd7,          32'h64A42341});
    vecs.push_back('{"unaligned pc9", 32'd9,          32'h000064A4});
    vecs.push_back('{"aligned pc0",   32'd0,          32'h00940333});
    vecs.push_back('{"range pc61",    32'd61,         32'h00000000});
    vecs.push_back('{"range pc63",    32'd63,         32'h00000000});
    vecs.push_back('{"wrap pcFFFFFFFE", 32'hFFFFFFFE, 32'h00000000});
    vecs.push_back('{"wrap pcFFFFFFFF", 32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"after wrap pc4", 32'd4,         32'h413902B3});

    // Reset held low for two cycles with an arbitrary PC.
    reset = 1'b1;
    PC    = 32'h00000005;
    #1 reset = 1'b0;
    #1 check("reset immediate", instruction_code, 32'h0);
    @(posedge clk); #1;
    check("reset cycle1", instruction_code, 32'h0);
    PC = 32'h00000008;
    @(posedge clk); #1;
    check("reset cycle2", instruction_code, 32'h0);

    // Release with PC=0; first edge captures the fetch.
    @(negedge clk);
    reset = 1'b1;
    fetch(32'd0);
    check("first fetch pc0", instruction_code, 32'h00940333);

    foreach (vecs[i]) begin
      fetch(vecs[i].pc);
      check(vecs[i].name, instruction_code, vecs[i].exp);
    end

    // Latency: PC changes mid-cycle have no effect until the next edge.
    fetch(32'd0);
    check("latency base pc0", instruction_code, 32'h00940333);
    #3 PC = 32'd4;
    @(negedge clk); #1;
    check("latency hold mid-cycle", instruction_code, 32'h00940333);
    @(posedge clk); #1;
    check("latency update pc4", instruction_code, 32'h413902B3);

    // Hold PC=4 for three edges.
    for (int e = 0; e < 3; e++) begin
      fetch(32'd4);
      check($sformatf("hold pc4 edge%0d", e), instruction_code, 32'h413902B3);
    end

    // Mid-run reset between edges: output clears at once.
    #2;
    t0 = $realtime;
    reset = 1'b0;
    #1;
    check("midrun reset immediate", instruction_code, 32'h0);
    if (($realtime - t0) >= 4.0) begin
      n_vec++; n_err++;
      $display("FAIL midrun reset timing: got %0t elapsed, expected < 4", $realtime - t0);
    end
    PC = 32'd0;
    @(posedge clk); #1;
    check("midrun reset held", instruction_code, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("release before edge", instruction_code, 32'h0);
    @(posedge clk); #1;
    check("release fetch pc0", instruction_code, 32'h00940333);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
